fpu_round_sched: RTL and testbench
==================================

Name: fpu_round_sched

Overview:
- Shares one rounding datapath (35-bit unrounded {sign, 31-bit exp/mantissa, G, R, S} → 32-bit IEEE single) between N_REQ FPU functional units (add, mul, div, cvt).
- Round-robin arbitration, per-request rounding-mode resolution (static or dynamic via frm), exception-flag generation and sticky fflags accumulation.
- Registered result output through a small FIFO with valid/ready backpressure toward writeback/CDB.

Parameters:
- N_REQ, 4, number of requesting units
- TAG_W, 6, width of the destination/ROB tag carried with each request
- FIFO_DEPTH, 2, output FIFO entries (power of 2, ≥2)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  request present, per unit
- req_data  in  N_REQ*35  unrounded operand per unit, bit 34 sign, 33:3 exp/mant, 2 G, 1 R, 0 S
- req_rm  in  N_REQ*3  instruction rm field per unit
- req_tag  in  N_REQ*TAG_W  tag per unit
- req_ready  out  N_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- frm  in  3  dynamic rounding mode from fcsr
- flags_clr  in  1  clear sticky fflags (CSR write)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  32  rounded result
- out_tag  out  TAG_W  tag of result
- out_src  out  $clog2(N_REQ)  index of originating unit
- out_flags  out  5  per-result {NV, DZ, OF, UF, NX}
- fflags  out  5  sticky accumulated flags, same order

Behaviour:
- Reset: req_ready=0, out_valid=0, out_data/out_tag/out_src/out_flags=0, fflags=0, RR pointer=0, FIFO empty. Reset mid-operation discards all FIFO contents and in-flight grants immediately.
- Grant: accept = FIFO not full OR (out_valid & out_ready). When accept, req_ready = one-hot of first valid requester starting at pointer, wrapping. req_ready=0 for non-valid units and when not accept. Combinational from req_valid.
- Pointer: on a transfer from unit i, pointer ← (i+1) mod N_REQ. Unchanged otherwise.
- rm resolution: rm=3'b111 → use frm. Effective rm 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM. 101/110, or dynamic with frm ∈ {101,110,111}, is illegal.
- round_up: RNE g&(r|s|lsb), lsb=in[3]. RTZ 0. RDN (g|r|s)&sign. RUP (g|r|s)&~sign. RMM g. Illegal: 0.
- Result: out_data = {sign, in[33:3] + (round_up & ~&in[33:26])}. Exponent all-ones input (inf/NaN) never increments.
- Flags:
  - NX = (g|r|s) & legal & ~&in[33:26].
  - OF = increment carried exponent to all-ones (result[30:23]=8'hFF, input exp ≠ 8'hFF). OF forces NX=1.
  - NV = illegal rm.
  - DZ = 0, UF = 0.
- Latency: transfer in cycle N → entry written at edge ending N; visible at out_valid in cycle N+1 if FIFO was empty. FIFO order = grant order.
- FIFO: simultaneous push and pop when full is permitted; count unchanged. Pop only when out_valid&out_ready.
- fflags: fflags ← (flags_clr ? 0 : fflags) | out_flags of each popped entry. Accumulated at pop, not push. Same-cycle clear and pop → popped flags survive.
- No combinational path from out_ready to out_data. out_ready → req_ready path is allowed.

Decomposition:
- fpu_pkg: rounding-mode constants (RNE/RTZ/RDN/RUP/RMM/DYN), fflags bit indices, typedef for the 35-bit unrounded struct {sign, expmant[30:0], g, r, s}.
- Sub-module: rr_arbiter (N-way round-robin, one-hot grant, pointer update on grant) — reusable by issue logic.
- Rounding is combinational in this block; FIFO is inline.

Test Plan:
- RNE tie, lsb=0: sign=0, expmant=31'h3F800000, GRS=100 → out_data 32'h3F800000, out_flags 5'b00001. Same with expmant=31'h3F800001 → 32'h3F800002, NX.
- Directed modes, sign=1, expmant=31'h3F800000, GRS=001: RDN → 32'hBF800001; RUP → 32'hBF800000; rm=111 with frm=010 → 32'hBF800001, NX; rm=101 → 32'hBF800000, flags 5'b10000.
- Overflow/saturation: expmant=31'h7F7FFFFF, GRS=111, RNE → 32'h7F800000, flags 5'b00101. Expmant=31'h7F800000, GRS=111 → unchanged, flags 0.
- Fairness: all 4 req_valid held high, out_ready=1 → grants 0,1,2,3,0,1 on consecutive cycles; out_src sequence matches one cycle later.
- Backpressure: out_ready=0, units valid → exactly 2 transfers, then req_ready=0. Raise out_ready → one pop+push per cycle, no loss, order preserved.
- fflags/reset: pop NX result, then pop OF result with flags_clr high same cycle → fflags=5'b00101. Assert reset with FIFO full → out_valid=0, fflags=0 immediately.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding-mode encodings, fflags bit positions,
// the unrounded operand layout and the single-precision rounding function.
package fpu_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;
    localparam logic [2:0] RM_DYN = 3'b111;

    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_NV = 4;

    typedef struct packed {
        logic        sign;
        logic [30:0] expmant;
        logic        g;
        logic        r;
        logic        s;
    } unrounded_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  flags;
    } rounded_t;

    // Infinity/NaN inputs (exponent all ones) pass through untouched and raise no NX.
    function automatic rounded_t round_value(input unrounded_t in, input logic [2:0] rm,
                                             input logic [2:0] frm);
        logic [2:0]  eff;
        logic        legal;
        logic        inexact;
        logic        exp_max;
        logic        round_up;
        logic [30:0] sum;
        rounded_t    res;
        eff     = (rm == RM_DYN) ? frm : rm;
        legal   = (eff <= RM_RMM);
        inexact = in.g | in.r | in.s;
        exp_max = &in.expmant[30:23];
        case (eff)
            RM_RNE:  round_up = in.g & (in.r | in.s | in.expmant[0]);
            RM_RTZ:  round_up = 1'b0;
            RM_RDN:  round_up = inexact & in.sign;
            RM_RUP:  round_up = inexact & ~in.sign;
            RM_RMM:  round_up = in.g;
            default: round_up = 1'b0;
        endcase
        sum            = in.expmant + {30'b0, round_up & ~exp_max};
        res.data       = {in.sign, sum};
        res.flags      = '0;
        res.flags[FLAG_NV] = ~legal;
        res.flags[FLAG_OF] = (&sum[30:23]) & ~exp_max;
        res.flags[FLAG_NX] = (inexact & legal & ~exp_max) | res.flags[FLAG_OF];
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant searched from the pointer upward,
// pointer moves just past the winner whenever a grant is issued.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             enable,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx
);

    logic [PTR_W-1:0] ptr;

    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N);
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/fpu_round_sched.sv
// Shared rounding stage for several FPU units: round-robin pick, combinational
// rounding, small result FIFO toward writeback, sticky fflags gathered at pop.
module fpu_round_sched
    import fpu_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int TAG_W      = 6,
    parameter int FIFO_DEPTH = 2,
    localparam int SRC_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*35-1:0]    req_data,
    input  logic [N_REQ*3-1:0]     req_rm,
    input  logic [N_REQ*TAG_W-1:0] req_tag,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [2:0]             frm,
    input  logic                   flags_clr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_data,
    output logic [TAG_W-1:0]       out_tag,
    output logic [SRC_W-1:0]       out_src,
    output logic [4:0]             out_flags,
    output logic [4:0]             fflags
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic [SRC_W-1:0] src;
        logic [4:0]       flags;
    } entry_t;

    entry_t           mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             pop;
    logic             push;
    logic             accept;
    logic [SRC_W-1:0] sel;
    unrounded_t       picked;
    rounded_t         rounded;
    entry_t           new_entry;
    entry_t           head;

    assign full   = (count == CW'(FIFO_DEPTH));
    assign pop    = out_valid & out_ready;
    assign accept = ~reset & (~full | pop);
    assign push   = |req_ready;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clock     (clock),
        .reset     (reset),
        .req       (req_valid),
        .enable    (accept),
        .grant     (req_ready),
        .grant_idx (sel)
    );

    assign picked          = unrounded_t'(req_data[int'(sel)*35 +: 35]);
    assign rounded         = round_value(picked, req_rm[int'(sel)*3 +: 3], frm);
    assign new_entry.data  = rounded.data;
    assign new_entry.flags = rounded.flags;
    assign new_entry.tag   = req_tag[int'(sel)*TAG_W +: TAG_W];
    assign new_entry.src   = sel;

    // Outputs come straight from storage, so out_ready never reaches out_data.
    assign head      = mem[rd_ptr];
    assign out_valid = (count != '0);
    assign out_data  = head.data;
    assign out_tag   = head.tag;
    assign out_src   = head.src;
    assign out_flags = head.flags;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            fflags <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A clear in the same cycle as a pop keeps the popped entry's flags.
            if (pop) begin
                fflags <= (flags_clr ? 5'b0 : fflags) | head.flags;
            end else if (flags_clr) begin
                fflags <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fpu_round_sched.sv
// Scoreboard bench for fpu_round_sched: arithmetic rounding model, queue of
// expected results, negedge monitor comparing grants, results and fflags.
module tb_fpu_round_sched;

    localparam int N_REQ = 4;
    localparam int TAG_W = 6;
    localparam int DEPTH = 2;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*35-1:0]    req_data;
    logic [N_REQ*3-1:0]     req_rm;
    logic [N_REQ*TAG_W-1:0] req_tag;
    logic [N_REQ-1:0]       req_ready;
    logic [2:0]             frm;
    logic                   flags_clr;
    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            out_data;
    logic [TAG_W-1:0]       out_tag;
    logic [1:0]             out_src;
    logic [4:0]             out_flags;
    logic [4:0]             fflags;

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic [1:0]       src;
        logic [4:0]       flags;
    } exp_t;

    exp_t       sb[$];
    int         model_ptr;
    logic [4:0] model_ff;
    int         n_checks;
    int         n_fail;
    int         xfer_count;

    fpu_round_sched #(.N_REQ(N_REQ), .TAG_W(TAG_W), .FIFO_DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_rm    (req_rm),
        .req_tag   (req_tag),
        .req_ready (req_ready),
        .frm       (frm),
        .flags_clr (flags_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_src   (out_src),
        .out_flags (out_flags),
        .fflags    (fflags)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Rounding described as "fraction beyond the lsb, in eighths" against the half point.
    function automatic void model_round(input logic [34:0] d, input logic [2:0] rm,
                                        input logic [2:0] f, output logic [31:0] res,
                                        output logic [4:0] fl);
        int unsigned mag;
        int unsigned frac;
        int unsigned newmag;
        int          mode;
        bit          sgn;
        bit          legal;
        bit          special;
        bit          up;
        bit          of;
        bit          nx;
        sgn     = d[34];
        mag     = {1'b0, d[33:3]};
        frac    = d[2:0];
        mode    = (rm == 3'd7) ? int'(f) : int'(rm);
        legal   = (mode <= 4);
        special = (mag >= 32'h7F80_0000);
        case (mode)
            0:       up = (frac > 4) || (frac == 4 && mag % 2 == 1);
            2:       up = sgn && frac != 0;
            3:       up = !sgn && frac != 0;
            4:       up = (frac >= 4);
            default: up = 0;
        endcase
        if (special || !legal) up = 0;
        newmag = mag + (up ? 1 : 0);
        of     = !special && newmag >= 32'h7F80_0000;
        nx     = (legal && !special && frac != 0) || of;
        res    = {sgn, newmag[30:0]};
        fl     = {!legal, 1'b0, of, 1'b0, nx};
    endfunction

    always @(negedge clock) begin
        logic [3:0]  exp_grant;
        bit          acc;
        int          u;
        int          sel;
        exp_t        e;
        logic [31:0] r;
        logic [4:0]  f;
        if (reset) begin
            sb.delete();
            model_ptr = 0;
            model_ff  = '0;
        end else begin
            check_output("out_valid", {31'b0, out_valid}, {31'b0, sb.size() > 0});
            check_output("fflags", {27'b0, fflags}, {27'b0, model_ff});
            acc       = (sb.size() < DEPTH) || (sb.size() > 0 && out_ready);
            exp_grant = '0;
            sel       = 0;
            if (acc) begin
                for (int k = 0; k < N_REQ; k++) begin
                    u = (model_ptr + k) % N_REQ;
                    if (req_valid[u] && exp_grant == 0) begin
                        exp_grant[u] = 1'b1;
                        sel          = u;
                    end
                end
            end
            check_output("req_ready", {28'b0, req_ready}, {28'b0, exp_grant});
            if (sb.size() > 0 && out_ready) begin
                e = sb.pop_front();
                check_output("out_data", out_data, e.data);
                check_output("out_tag", {26'b0, out_tag}, {26'b0, e.tag});
                check_output("out_src", {30'b0, out_src}, {30'b0, e.src});
                check_output("out_flags", {27'b0, out_flags}, {27'b0, e.flags});
                model_ff = (flags_clr ? 5'b0 : model_ff) | e.flags;
            end else if (flags_clr) begin
                model_ff = '0;
            end
            if (exp_grant != 0) begin
                model_round(req_data[sel*35 +: 35], req_rm[sel*3 +: 3], frm, r, f);
                e.data  = r;
                e.flags = f;
                e.tag   = req_tag[sel*TAG_W +: TAG_W];
                e.src   = 2'(sel);
                sb.push_back(e);
                model_ptr = (sel + 1) % N_REQ;
                xfer_count++;
            end
        end
    end

    task automatic randomize_inputs();
        logic [30:0] em;
        for (int i = 0; i < N_REQ; i++) begin
            case ($urandom_range(0, 3))
                0:       em = 31'h7F7F_FFFF - 31'($urandom_range(0, 3));
                1:       em = 31'h7F80_0000 + 31'($urandom_range(0, 3));
                default: em = 31'($urandom);
            endcase
            req_data[i*35 +: 35]     = {1'($urandom), em, 3'($urandom)};
            req_rm[i*3 +: 3]         = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
            req_tag[i*TAG_W +: TAG_W] = TAG_W'($urandom);
        end
        frm = 3'($urandom_range(0, 7));
    endtask

    task automatic apply_stimulus(input string name, input int unit, input logic sgn,
                                  input logic [30:0] em, input logic [2:0] grs,
                                  input logic [2:0] rm, input logic [2:0] f,
                                  input logic [31:0] exp_d, input logic [4:0] exp_f);
        @(posedge clock); #1;
        out_ready                    = 1'b0;
        req_valid                    = 4'b0001 << unit;
        req_data[unit*35 +: 35]      = {sgn, em, grs};
        req_rm[unit*3 +: 3]          = rm;
        req_tag[unit*TAG_W +: TAG_W] = TAG_W'(unit + 8);
        frm                          = f;
        @(posedge clock); #1;
        req_valid = '0;
        @(negedge clock);
        check_output({name, "_data"}, out_data, exp_d);
        check_output({name, "_flags"}, {27'b0, out_flags}, {27'b0, exp_f});
        @(posedge clock); #1;
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    initial begin
        int start;
        n_checks   = 0;
        n_fail     = 0;
        xfer_count = 0;
        model_ptr  = 0;
        model_ff   = '0;
        reset      = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        req_rm     = '0;
        req_tag    = '0;
        frm        = '0;
        flags_clr  = 1'b0;
        out_ready  = 1'b0;
        #1;
        check_output("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("rst_out_data", out_data, 32'd0);
        check_output("rst_fflags", {27'b0, fflags}, 32'd0);
        check_output("rst_req_ready", {28'b0, req_ready}, 32'd0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        apply_stimulus("rne_tie_even", 0, 1'b0, 31'h3F80_0000, 3'b100, 3'b000, 3'b000, 32'h3F80_0000, 5'b00001);
        apply_stimulus("rne_tie_odd", 1, 1'b0, 31'h3F80_0001, 3'b100, 3'b000, 3'b000, 32'h3F80_0002, 5'b00001);
        apply_stimulus("rdn_neg", 2, 1'b1, 31'h3F80_0000, 3'b001, 3'b010, 3'b000, 32'hBF80_0001, 5'b00001);
        apply_stimulus("rup_neg", 3, 1'b1, 31'h3F80_0000, 3'b001, 3'b011, 3'b000, 32'hBF80_0000, 5'b00001);
        apply_stimulus("dyn_rdn", 0, 1'b1, 31'h3F80_0000, 3'b001, 3'b111, 3'b010, 32'hBF80_0001, 5'b00001);
        apply_stimulus("illegal_rm", 1, 1'b1, 31'h3F80_0000, 3'b001, 3'b101, 3'b000, 32'hBF80_0000, 5'b10000);
        apply_stimulus("overflow", 2, 1'b0, 31'h7F7F_FFFF, 3'b111, 3'b000, 3'b000, 32'h7F80_0000, 5'b00101);
        apply_stimulus("inf_hold", 3, 1'b0, 31'h7F80_0000, 3'b111, 3'b000, 3'b000, 32'h7F80_0000, 5'b00000);

        // Fairness right after reset so the pointer starts at unit 0.
        pulse_reset();
        randomize_inputs();
        out_ready = 1'b1;
        req_valid = 4'hF;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            check_output("fair_grant", {28'b0, req_ready}, 32'd1 << (c % 4));
            if (c > 0) check_output("fair_src", {30'b0, out_src}, 32'((c - 1) % 4));
        end
        @(posedge clock); #1;
        req_valid = '0;
        repeat (3) @(posedge clock);

        #1;
        out_ready = 1'b0;
        start     = xfer_count;
        randomize_inputs();
        req_valid = 4'hF;
        repeat (4) @(posedge clock);
        #1;
        check_output("bp_transfers", 32'(xfer_count - start), 32'd2);
        check_output("bp_ready_low", {28'b0, req_ready}, 32'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            randomize_inputs();
        end
        req_valid = '0;
        repeat (4) @(posedge clock);

        // Sticky flags: NX then OF popped, clear coinciding with the second pop.
        pulse_reset();
        out_ready          = 1'b0;
        req_valid          = 4'b0001;
        req_data[0 +: 35]  = {1'b0, 31'h3F80_0000, 3'b001};
        req_rm[0 +: 3]     = 3'b000;
        @(posedge clock); #1;
        req_valid          = 4'b0010;
        req_data[35 +: 35] = {1'b0, 31'h7F7F_FFFF, 3'b111};
        req_rm[3 +: 3]     = 3'b000;
        @(posedge clock); #1;
        req_valid = '0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        flags_clr = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        flags_clr = 1'b0;
        check_output("fflags_sticky", {27'b0, fflags}, 32'h05);

        randomize_inputs();
        req_valid = 4'b1100;
        repeat (2) @(posedge clock);
        #1;
        check_output("full_before_rst", {31'b0, out_valid}, 32'd1);
        req_valid = 4'hF;
        reset     = 1'b1;
        #1;
        check_output("rst_mid_valid", {31'b0, out_valid}, 32'd0);
        check_output("rst_mid_fflags", {27'b0, fflags}, 32'd0);
        check_output("rst_mid_ready", {28'b0, req_ready}, 32'd0);
        @(posedge clock); #1;
        reset     = 1'b0;
        req_valid = '0;

        for (int c = 0; c < 400; c++) begin
            @(posedge clock); #1;
            randomize_inputs();
            req_valid = 4'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            flags_clr = ($urandom_range(0, 19) == 0);
        end
        @(posedge clock); #1;
        req_valid = '0;
        flags_clr = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        check_output("drained", {31'b0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
